// File: rtl/alu_issue_unit.sv
// ---------------------------------------------------------------------------
// alu_issue_unit
//
// Issue and writeback stage that feeds an external combinational ALU.
// One MIPS R-type instruction is in flight at a time. The instruction moves
// through three states:
//   IDLE : accept an instruction, read rs/rt, decode the funct field
//   EXEC : operands and ALU op are held stable, the ALU result is captured
//   WB   : done pulses and the captured result is written to rd
// A new instruction can be accepted every third cycle.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   instr_valid  instr holds a valid instruction
//   instr_ready  unit can accept (IDLE state and not in reset)
//   instr        [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd, [5:0] funct
//   alu_a        registered operand A to the ALU
//   alu_b        registered operand B to the ALU
//   alu_funct    registered ALU operation code
//   alu_out      combinational ALU result
//   done         one-cycle retire pulse
//   illegal      retired instruction was not decodable (valid with done)
//   wb_rd        destination register of the retired instruction
//   wb_data      value written back (0 for illegal instructions)
//   dbg_addr     debug read address into the register file
//   dbg_data     combinational debug read data (register 0 reads 0)
// ---------------------------------------------------------------------------
module alu_issue_unit #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int FUNCT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [31:0]        instr,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [FUNCT_W-1:0] alu_funct,
    input  logic [DATA_W-1:0]  alu_out,
    output logic               done,
    output logic               illegal,
    output logic [REG_AW-1:0]  wb_rd,
    output logic [DATA_W-1:0]  wb_data,
    input  logic [REG_AW-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    localparam int NREG = 2 ** REG_AW;

    // ALU operation codes understood by the external ALU
    localparam logic [FUNCT_W-1:0] F_ADD  = FUNCT_W'(0);
    localparam logic [FUNCT_W-1:0] F_SUB  = FUNCT_W'(1);
    localparam logic [FUNCT_W-1:0] F_ADDU = FUNCT_W'(2);
    localparam logic [FUNCT_W-1:0] F_SUBU = FUNCT_W'(3);
    localparam logic [FUNCT_W-1:0] F_AND  = FUNCT_W'(4);
    localparam logic [FUNCT_W-1:0] F_OR   = FUNCT_W'(5);
    localparam logic [FUNCT_W-1:0] F_SLLV = FUNCT_W'(6);
    localparam logic [FUNCT_W-1:0] F_SRLV = FUNCT_W'(7);
    localparam logic [FUNCT_W-1:0] F_SLTU = FUNCT_W'(8);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [DATA_W-1:0]  regs [NREG];

    logic [5:0]         op;
    logic [5:0]         mips_funct;
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
    logic [REG_AW-1:0]  rd;
    logic               unused_shamt;

    logic [DATA_W-1:0]  rs_val;
    logic [DATA_W-1:0]  rt_val;
    logic [FUNCT_W-1:0] dec_funct;
    logic               dec_illegal;

    logic [REG_AW-1:0]  rd_q;
    logic               ill_q;

    // Instruction field extraction; the shamt field is not used by this unit
    assign op           = instr[31:26];
    assign rs           = REG_AW'(instr[25:21]);
    assign rt           = REG_AW'(instr[20:16]);
    assign rd           = REG_AW'(instr[15:11]);
    assign mips_funct   = instr[5:0];
    assign unused_shamt = ^instr[10:6];

    // Register file reads. Register 0 is never written, but the read path
    // forces it to zero so it stays hardwired regardless of storage contents.
    assign rs_val   = (rs == '0)       ? '0 : regs[rs];
    assign rt_val   = (rt == '0)       ? '0 : regs[rt];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

    // Decode of the MIPS funct field into the ALU operation code. Anything
    // that is not R-type (op != 0) or uses an unsupported funct is flagged
    // illegal and gets the neutral code 0.
    always_comb begin
        dec_funct   = '0;
        dec_illegal = 1'b0;
        case (mips_funct)
            6'h20:   dec_funct = F_ADD;
            6'h22:   dec_funct = F_SUB;
            6'h21:   dec_funct = F_ADDU;
            6'h23:   dec_funct = F_SUBU;
            6'h24:   dec_funct = F_AND;
            6'h25:   dec_funct = F_OR;
            6'h04:   dec_funct = F_SLLV;
            6'h06:   dec_funct = F_SRLV;
            6'h2B:   dec_funct = F_SLTU;
            default: dec_illegal = 1'b1;
        endcase
        if ((op != 6'h00) || dec_illegal) begin
            dec_illegal = 1'b1;
            dec_funct   = '0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake/retire outputs. Both ready and done are held
    // low while reset is asserted so nothing is accepted or reported during
    // a reset that lands mid-instruction.
    always_comb begin
        next_state  = state;
        instr_ready = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = !rst;
                if (instr_valid && !rst) begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                next_state = WB;
            end
            WB: begin
                done       = !rst;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The illegal flag is only meaningful while done is high
    assign illegal = done & ill_q;
    assign wb_rd   = rd_q;

    // Datapath: operand capture at acceptance, result capture at the end of
    // EXEC, and register write at the end of WB. Writing at the end of WB
    // means an instruction accepted in the following IDLE cycle already
    // sees the new value, so no forwarding path is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            alu_a     <= '0;
            alu_b     <= '0;
            alu_funct <= '0;
            rd_q      <= '0;
            ill_q     <= 1'b0;
            wb_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid && instr_ready) begin
                        alu_a     <= dec_illegal ? '0 : rs_val;
                        alu_b     <= dec_illegal ? '0 : rt_val;
                        alu_funct <= dec_funct;
                        rd_q      <= rd;
                        ill_q     <= dec_illegal;
                    end
                end
                EXEC: begin
                    wb_data <= ill_q ? '0 : alu_out;
                end
                WB: begin
                    if (!ill_q && (rd_q != '0)) begin
                        regs[rd_q] <= wb_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_unit
//
// Drives MIPS R-type instructions into alu_issue_unit, provides a behavioural
// ALU on the other side, and compares every cycle of each instruction against
// a register-file model that applies MIPS semantics directly.
// ---------------------------------------------------------------------------
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_funct;
    logic [31:0] alu_out;
    logic        done;
    logic        illegal;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    logic        force_alu;
    logic [31:0] force_val;

    logic [31:0] mregs [32];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          hs_cyc = 0;

    alu_issue_unit #(
        .DATA_W (32),
        .REG_AW (5),
        .FUNCT_W(5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_funct  (alu_funct),
        .alu_out    (alu_out),
        .done       (done),
        .illegal    (illegal),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // Free-running clock and cycle counter
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External ALU stand-in; can be overridden to inject a chosen result
    always_comb begin
        alu_out = 32'hDEAD_BEEF;
        if (force_alu) begin
            alu_out = force_val;
        end else begin
            case (alu_funct)
                5'd0, 5'd2: alu_out = alu_a + alu_b;
                5'd1, 5'd3: alu_out = alu_a - alu_b;
                5'd4:       alu_out = alu_a & alu_b;
                5'd5:       alu_out = alu_a | alu_b;
                5'd6:       alu_out = alu_b << alu_a[4:0];
                5'd7:       alu_out = alu_b >> alu_a[4:0];
                5'd8:       alu_out = {31'd0, (alu_a < alu_b)};
                default:    alu_out = 32'hDEAD_BEEF;
            endcase
        end
    end

    // Hard stop in case something wedges the run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired got=running exp=finished");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [5:0] mf);
        return {op, rs, rt, rd, 5'd0, mf};
    endfunction

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] mf);
        if (op != 6'h00) return 1'b0;
        return (mf == 6'h20) || (mf == 6'h21) || (mf == 6'h22) || (mf == 6'h23) ||
               (mf == 6'h24) || (mf == 6'h25) || (mf == 6'h04) || (mf == 6'h06) ||
               (mf == 6'h2B);
    endfunction

    function automatic logic [4:0] exp_funct(input logic [5:0] mf);
        case (mf)
            6'h20:   return 5'b00000;
            6'h22:   return 5'b00001;
            6'h21:   return 5'b00010;
            6'h23:   return 5'b00011;
            6'h24:   return 5'b00100;
            6'h25:   return 5'b00101;
            6'h04:   return 5'b00110;
            6'h06:   return 5'b00111;
            6'h2B:   return 5'b01000;
            default: return 5'b00000;
        endcase
    endfunction

    // MIPS semantics of each funct: a = reg[rs], b = reg[rt]
    function automatic logic [31:0] mips_result(input logic [5:0] mf, input logic [31:0] a,
                                                input logic [31:0] b);
        case (mf)
            6'h20, 6'h21: return a + b;
            6'h22, 6'h23: return a - b;
            6'h24:        return a & b;
            6'h25:        return a | b;
            6'h04:        return b << a[4:0];
            6'h06:        return b >> a[4:0];
            6'h2B:        return (a < b) ? 32'd1 : 32'd0;
            default:      return 32'd0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Issue one instruction starting just after a falling edge and follow it
    // through EXEC, WB and the next IDLE cycle. Returns just after the IDLE
    // falling edge so the next call can hand off back-to-back.
    task automatic applyStimulus(input logic [31:0] ins, input logic frc,
                                 input logic [31:0] fval, input logic hold);
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        ok;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] er;
        logic [4:0]  ef;
        int          waited;
        rs = ins[25:21];
        rt = ins[20:16];
        rd = ins[15:11];
        ok = is_legal(ins[31:26], ins[5:0]);
        force_alu   = frc;
        force_val   = fval;
        instr       = ins;
        instr_valid = 1'b1;
        waited = 0;
        while (instr_ready !== 1'b1 && waited < 10) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (instr_ready !== 1'b1) begin
            checkOutput("hs_timeout", {31'd0, instr_ready}, 32'd1);
            instr_valid = 1'b0;
            return;
        end
        ea = ok ? mregs[rs] : 32'd0;
        eb = ok ? mregs[rt] : 32'd0;
        ef = ok ? exp_funct(ins[5:0]) : 5'd0;
        er = !ok ? 32'd0 : (frc ? fval : mips_result(ins[5:0], mregs[rs], mregs[rt]));
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        if (!hold) instr_valid = 1'b0;

        @(negedge clk);
        checkOutput("exec_alu_a", alu_a, ea);
        checkOutput("exec_alu_b", alu_b, eb);
        checkOutput("exec_alu_funct", {27'd0, alu_funct}, {27'd0, ef});
        checkOutput("exec_done", {31'd0, done}, 32'd0);
        checkOutput("exec_ready", {31'd0, instr_ready}, 32'd0);

        @(negedge clk);
        checkOutput("wb_done", {31'd0, done}, 32'd1);
        checkOutput("wb_illegal", {31'd0, illegal}, {31'd0, !ok});
        checkOutput("wb_rd", {27'd0, wb_rd}, {27'd0, rd});
        checkOutput("wb_data", wb_data, er);
        checkOutput("wb_ready", {31'd0, instr_ready}, 32'd0);
        dbg_addr = rd;
        #1;
        checkOutput("wb_dbg_old", dbg_data, mregs[rd]);
        if (ok && rd != 5'd0) mregs[rd] = er;

        @(negedge clk);
        checkOutput("idle_dbg_new", dbg_data, mregs[rd]);
        checkOutput("idle_done", {31'd0, done}, 32'd0);
        checkOutput("idle_ready", {31'd0, instr_ready}, 32'd1);
    endtask

    initial begin
        int          first_hs;
        logic [5:0]  legal_list [9];
        logic [5:0]  op;
        logic [5:0]  mf;
        logic [31:0] ins;

        legal_list = '{6'h20, 6'h22, 6'h21, 6'h23, 6'h24, 6'h25, 6'h04, 6'h06, 6'h2B};
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;

        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'd0;
        dbg_addr    = 5'd0;
        force_alu   = 1'b0;
        force_val   = 32'd0;

        // Reset for two cycles, outputs and whole register file must be zero
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", {31'd0, instr_ready}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_illegal", {31'd0, illegal}, 32'd0);
        checkOutput("rst_alu_a", alu_a, 32'd0);
        checkOutput("rst_alu_b", alu_b, 32'd0);
        checkOutput("rst_alu_funct", {27'd0, alu_funct}, 32'd0);
        checkOutput("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        checkOutput("rst_wb_data", wb_data, 32'd0);
        for (int a = 0; a < 32; a++) begin
            dbg_addr = a[4:0];
            #1;
            checkOutput("rst_dbg", dbg_data, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ready", {31'd0, instr_ready}, 32'd1);

        // Preload r1=5 and r2=3 through a forced ALU result
        applyStimulus(mk(6'h00, 5'd0, 5'd0, 5'd1, 6'h21), 1'b1, 32'd5, 1'b0);
        applyStimulus(mk(6'h00, 5'd0, 5'd0, 5'd2, 6'h21), 1'b1, 32'd3, 1'b0);
        checkOutput("r1_is_5", mregs[1], 32'd5);

        // sub r3, r1, r2
        applyStimulus(mk(6'h00, 5'd1, 5'd2, 5'd3, 6'h22), 1'b0, 32'd0, 1'b0);
        dbg_addr = 5'd3;
        #1;
        checkOutput("r3_is_2", dbg_data, 32'd2);

        // Illegal funct and illegal opcode
        applyStimulus(32'h0000_003F, 1'b0, 32'd0, 1'b0);
        applyStimulus(mk(6'h08, 5'd1, 5'd2, 5'd4, 6'h20), 1'b0, 32'd0, 1'b0);

        // Write to r0 is discarded
        applyStimulus(mk(6'h00, 5'd1, 5'd2, 5'd0, 6'h21), 1'b0, 32'd0, 1'b0);

        // Back-to-back dependent pair with instr_valid held high
        applyStimulus(mk(6'h00, 5'd1, 5'd2, 5'd4, 6'h25), 1'b0, 32'd0, 1'b1);
        first_hs = hs_cyc;
        applyStimulus(mk(6'h00, 5'd4, 5'd1, 5'd5, 6'h24), 1'b0, 32'd0, 1'b0);
        checkOutput("b2b_gap", hs_cyc - first_hs, 32'd3);
        dbg_addr = 5'd5;
        #1;
        checkOutput("r5_is_5", dbg_data, 32'd5);

        // Random values into r6, r7, then randomized traffic over r0..r7
        applyStimulus(mk(6'h00, 5'd0, 5'd0, 5'd6, 6'h21), 1'b1, $urandom, 1'b0);
        applyStimulus(mk(6'h00, 5'd0, 5'd0, 5'd7, 6'h21), 1'b1, $urandom, 1'b0);
        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'h00;
            mf = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_list[$urandom_range(0, 8)];
            ins = mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), mf);
            ins[10:6] = 5'($urandom);
            applyStimulus(ins, 1'b0, 32'd0, ($urandom_range(0, 1) == 1));
        end

        // Reset during EXEC drops the instruction and clears the register file
        instr       = mk(6'h00, 5'd1, 5'd2, 5'd6, 6'h21);
        instr_valid = 1'b1;
        force_alu   = 1'b0;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_done", {31'd0, done}, 32'd0);
        checkOutput("mid_rst_ready", {31'd0, instr_ready}, 32'd0);
        checkOutput("mid_rst_alu_a", alu_a, 32'd0);
        checkOutput("mid_rst_alu_b", alu_b, 32'd0);
        checkOutput("mid_rst_wb_data", wb_data, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        @(negedge clk);
        checkOutput("mid_rst_idle_ready", {31'd0, instr_ready}, 32'd1);
        checkOutput("mid_rst_idle_done", {31'd0, done}, 32'd0);
        for (int a = 1; a < 8; a++) begin
            dbg_addr = a[4:0];
            #1;
            checkOutput("mid_rst_dbg", dbg_data, mregs[a]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
